// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage RV32I core. Produces the
//   PC / pipeline-register write enables, bubble flushes and the redirect
//   select. It handles:
//     - load-use bubbles,
//     - branch/jump mispredict recovery, including the wrong-path word that
//       the synchronous IMEM returns one cycle after the redirect,
//     - data-memory busy freezes.
//   It also keeps saturating performance counters for predictor evaluation.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   id_*                Decode-stage instruction info (valid, sources, usage)
//   ex_*                Execute-stage info (valid, load, rd, branch, mispredict)
//   mem_busy_i          data memory not ready; the whole pipeline holds
//   clr_cnt_i           synchronous clear of the performance counters
//   pc_we_o, pc_sel_o   PC load enable; 1 selects the resolved target
//   ifid_we_o/_flush_o  IF/ID load enable / load bubble (flush wins)
//   idex_we_o/_flush_o  ID/EX (and later) load enable / load bubble
//   *_cnt_o             branch, redirect and load-use stall counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_valid_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_is_branch_i,
   input  logic             ex_mispredict_i,
   input  logic             mem_busy_i,
   input  logic             clr_cnt_i,
   output logic             pc_we_o,
   output logic             pc_sel_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_we_o,
   output logic             idex_flush_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispredict_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      KILL = 1'b1
   } state_t;

   state_t           state_r;
   logic             busy_s;
   logic             redirect_s;
   logic             rs1_hit_s;
   logic             rs2_hit_s;
   logic             lu_hazard_s;
   logic             branch_ev_s;
   logic             stall_ev_s;
   logic [CNT_W-1:0] branch_cnt_r;
   logic [CNT_W-1:0] mispredict_cnt_r;
   logic [CNT_W-1:0] stall_cnt_r;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Hazard and event decode from the current stage contents.
   always_comb begin
      busy_s      = mem_busy_i;
      // Execute is held stable while busy, so a mispredict waits for the
      // first non-busy cycle.
      redirect_s  = ex_valid_i & ex_mispredict_i & ~busy_s;
      // Writes to x0 never create a dependency.
      rs1_hit_s   = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
      rs2_hit_s   = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
      lu_hazard_s = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                    id_valid_i & (rs1_hit_s | rs2_hit_s);
      branch_ev_s = ex_valid_i & ex_is_branch_i & ~busy_s;
      // In KILL, Decode holds the wrong-path bubble, so no stall is taken.
      stall_ev_s  = (state_r == RUN) & lu_hazard_s & ~busy_s & ~redirect_s;
   end

   // Control outputs: reset > busy > redirect > KILL > load-use > default.
   always_comb begin
      pc_we_o      = 1'b1;
      pc_sel_o     = 1'b0;
      ifid_we_o    = 1'b1;
      ifid_flush_o = 1'b0;
      idex_we_o    = 1'b1;
      idex_flush_o = 1'b0;
      if (rst_i) begin
         pc_we_o      = 1'b0;
         ifid_we_o    = 1'b0;
         idex_we_o    = 1'b0;
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (busy_s) begin
         pc_we_o   = 1'b0;
         ifid_we_o = 1'b0;
         idex_we_o = 1'b0;
      end else if (redirect_s) begin
         pc_sel_o     = 1'b1;
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else begin
         case (state_r)
            KILL: begin
               // Discard the wrong-path word IMEM returns after the redirect.
               ifid_flush_o = 1'b1;
            end
            RUN: begin
               if (lu_hazard_s) begin
                  pc_we_o      = 1'b0;
                  ifid_we_o    = 1'b0;
                  idex_flush_o = 1'b1;
               end else begin
                  pc_we_o = 1'b1;
               end
            end
            default: begin
               ifid_flush_o = 1'b1;
            end
         endcase
      end
   end

   // Sequencing state and saturating performance counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r          <= RUN;
         branch_cnt_r     <= {CNT_W{1'b0}};
         mispredict_cnt_r <= {CNT_W{1'b0}};
         stall_cnt_r      <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            RUN, KILL: begin
               if (busy_s) begin
                  state_r <= state_r;
               end else if (redirect_s) begin
                  state_r <= KILL;
               end else begin
                  state_r <= RUN;
               end
            end
            default: state_r <= RUN;
         endcase

         if (clr_cnt_i) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
            stall_cnt_r      <= {CNT_W{1'b0}};
         end else begin
            if (branch_ev_s) begin
               branch_cnt_r <= sat_inc(branch_cnt_r);
            end
            if (redirect_s) begin
               mispredict_cnt_r <= sat_inc(mispredict_cnt_r);
            end
            if (stall_ev_s) begin
               stall_cnt_r <= sat_inc(stall_cnt_r);
            end
         end
      end
   end

   assign branch_cnt_o     = branch_cnt_r;
   assign mispredict_cnt_o = mispredict_cnt_r;
   assign stall_cnt_o      = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed testbench for hazard_ctrl, built with CNT_W=4 so that counter
//   saturation is reachable. Control outputs are compared as the packed
//   vector {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush}:
//     default 101010   reset 000101   busy 000000
//     redirect 111111  kill 101110    load-use 000011
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             id_valid_i;
   logic [4:0]       id_rs1_i;
   logic [4:0]       id_rs2_i;
   logic             id_uses_rs1_i;
   logic             id_uses_rs2_i;
   logic             ex_valid_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rd_i;
   logic             ex_is_branch_i;
   logic             ex_mispredict_i;
   logic             mem_busy_i;
   logic             clr_cnt_i;
   logic             pc_we_o, pc_sel_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o;
   logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o, stall_cnt_o;
   logic [5:0]       ctl;
   int               n_tests = 0;
   int               n_fail  = 0;

   localparam logic [5:0] C_DEF  = 6'b101010;
   localparam logic [5:0] C_RST  = 6'b000101;
   localparam logic [5:0] C_BUSY = 6'b000000;
   localparam logic [5:0] C_RED  = 6'b111111;
   localparam logic [5:0] C_KILL = 6'b101110;
   localparam logic [5:0] C_LU   = 6'b000011;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
      .ex_valid_i(ex_valid_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
      .ex_is_branch_i(ex_is_branch_i), .ex_mispredict_i(ex_mispredict_i),
      .mem_busy_i(mem_busy_i), .clr_cnt_i(clr_cnt_i),
      .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .ifid_we_o(ifid_we_o),
      .ifid_flush_o(ifid_flush_o), .idex_we_o(idex_we_o), .idex_flush_o(idex_flush_o),
      .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_we_o, pc_sel_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
      id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
      ex_valid_i = 1'b0; ex_memread_i = 1'b0; ex_rd_i = 5'd0;
      ex_is_branch_i = 1'b0; ex_mispredict_i = 1'b0;
      mem_busy_i = 1'b0; clr_cnt_i = 1'b0;
   endtask

   task automatic mispredict_in();
      ex_valid_i = 1'b1; ex_is_branch_i = 1'b1; ex_mispredict_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; idle();
      #1;
      n_tests++; if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl0 got %b want %b", ctl, C_RST); end
      tick();
      n_tests++; if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl1 got %b want %b", ctl, C_RST); end
      tick();
      rst_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL idle_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o, stall_cnt_o} !== 12'h000) begin
         n_fail++; $display("FAIL reset_cnt got %h want 000", {branch_cnt_o, mispredict_cnt_o, stall_cnt_o}); end
   endtask

   task automatic test_load_use();
      // LW x5 in Execute, ADD reading x5 in Decode.
      ex_valid_i = 1'b1; ex_memread_i = 1'b1; ex_rd_i = 5'd5;
      id_valid_i = 1'b1; id_rs1_i = 5'd5; id_uses_rs1_i = 1'b1;
      #1;
      n_tests++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs1_ctl got %b want %b", ctl, C_LU); end
      tick();
      ex_valid_i = 1'b0; ex_memread_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL lu_after_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt_o); end
      // Load to x0 never stalls.
      ex_valid_i = 1'b1; ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL lu_x0_ctl got %b want %b", ctl, C_DEF); end
      tick();
      n_tests++; if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL lu_x0_cnt got %0d want 1", stall_cnt_o); end
      // Match on rs2 that the instruction does not read: no stall.
      ex_rd_i = 5'd7; id_uses_rs1_i = 1'b0; id_rs1_i = 5'd3; id_rs2_i = 5'd7; id_uses_rs2_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL lu_unused_rs2_ctl got %b want %b", ctl, C_DEF); end
      // Now it reads rs2: stall.
      id_uses_rs2_i = 1'b1;
      #1;
      n_tests++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2_ctl got %b want %b", ctl, C_LU); end
      tick();
      // Non-load producer in Execute: no stall.
      ex_memread_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL lu_nonload_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if (stall_cnt_o !== 4'd2) begin n_fail++; $display("FAIL lu_rs2_cnt got %0d want 2", stall_cnt_o); end
      idle(); tick();
   endtask

   task automatic test_mispredict();
      // Mispredict flag without a valid instruction does nothing.
      ex_mispredict_i = 1'b1;
      #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL mp_invalid_ctl got %b want %b", ctl, C_DEF); end
      mispredict_in();
      #1;
      n_tests++; if (ctl !== C_RED) begin n_fail++; $display("FAIL mp_T_ctl got %b want %b", ctl, C_RED); end
      tick(); idle(); #1;
      n_tests++; if (ctl !== C_KILL) begin n_fail++; $display("FAIL mp_T1_ctl got %b want %b", ctl, C_KILL); end
      tick();
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL mp_T2_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o} !== 8'h11) begin
         n_fail++; $display("FAIL mp_cnt got %h want 11", {branch_cnt_o, mispredict_cnt_o}); end
   endtask

   task automatic test_busy_mispredict();
      mispredict_in(); mem_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (ctl !== C_BUSY) begin n_fail++; $display("FAIL bm_busy%0d_ctl got %b want %b", i, ctl, C_BUSY); end
         tick();
      end
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o} !== 8'h11) begin
         n_fail++; $display("FAIL bm_held_cnt got %h want 11", {branch_cnt_o, mispredict_cnt_o}); end
      mem_busy_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_RED) begin n_fail++; $display("FAIL bm_redirect_ctl got %b want %b", ctl, C_RED); end
      tick(); idle(); #1;
      n_tests++; if (ctl !== C_KILL) begin n_fail++; $display("FAIL bm_kill_ctl got %b want %b", ctl, C_KILL); end
      tick();
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o} !== 8'h22) begin
         n_fail++; $display("FAIL bm_cnt got %h want 22", {branch_cnt_o, mispredict_cnt_o}); end
   endtask

   task automatic test_busy_kill();
      mispredict_in(); tick(); idle();
      mem_busy_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (ctl !== C_BUSY) begin n_fail++; $display("FAIL bk_busy%0d_ctl got %b want %b", i, ctl, C_BUSY); end
         tick();
      end
      mem_busy_i = 1'b0;
      #1;
      n_tests++; if (ctl !== C_KILL) begin n_fail++; $display("FAIL bk_kill_ctl got %b want %b", ctl, C_KILL); end
      tick();
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL bk_after_ctl got %b want %b", ctl, C_DEF); end
   endtask

   task automatic test_back_to_back();
      mispredict_in(); tick();
      // Second redirect while in KILL.
      #1;
      n_tests++; if (ctl !== C_RED) begin n_fail++; $display("FAIL b2b_red2_ctl got %b want %b", ctl, C_RED); end
      tick(); idle(); #1;
      n_tests++; if (ctl !== C_KILL) begin n_fail++; $display("FAIL b2b_kill_ctl got %b want %b", ctl, C_KILL); end
      tick();
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL b2b_after_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o} !== 8'h55) begin
         n_fail++; $display("FAIL b2b_cnt got %h want 55", {branch_cnt_o, mispredict_cnt_o}); end
   endtask

   task automatic test_saturation();
      ex_valid_i = 1'b1; ex_is_branch_i = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      n_tests++; if (branch_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_branch got %0d want 15", branch_cnt_o); end
      n_tests++; if (mispredict_cnt_o !== 4'd5) begin n_fail++; $display("FAIL sat_mispredict got %0d want 5", mispredict_cnt_o); end
      // Clear wins over a same-cycle increment.
      clr_cnt_i = 1'b1; tick(); clr_cnt_i = 1'b0; idle(); #1;
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o, stall_cnt_o} !== 12'h000) begin
         n_fail++; $display("FAIL clr_cnt got %h want 000", {branch_cnt_o, mispredict_cnt_o, stall_cnt_o}); end
   endtask

   task automatic test_reset_in_kill();
      mispredict_in(); tick(); idle();
      rst_i = 1'b1;
      #1;
      n_tests++; if (ctl !== C_RST) begin n_fail++; $display("FAIL rk_reset_ctl got %b want %b", ctl, C_RST); end
      tick(); rst_i = 1'b0; #1;
      n_tests++; if (ctl !== C_DEF) begin n_fail++; $display("FAIL rk_run_ctl got %b want %b", ctl, C_DEF); end
      n_tests++; if ({branch_cnt_o, mispredict_cnt_o} !== 8'h00) begin
         n_fail++; $display("FAIL rk_cnt got %h want 00", {branch_cnt_o, mispredict_cnt_o}); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mispredict();
      test_busy_mispredict();
      test_busy_kill();
      test_back_to_back();
      test_saturation();
      test_reset_in_kill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
